// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared constants and types for the interrupt controller.
//   NUM_IRQ      - number of interrupt lines
//   OFF_*        - register offsets from BASE_ADDR
//   irq_state_t  - request/acknowledge sequencer states
//   prio_id()    - fixed-priority encoder, lowest index wins
package irq_ctrl_pkg;

  localparam int NUM_IRQ = 4;

  localparam logic [2:0] OFF_MASK = 3'd0;
  localparam logic [2:0] OFF_PEND = 3'd1;
  localparam logic [2:0] OFF_EDGE = 3'd2;
  localparam logic [2:0] OFF_STAT = 3'd3;
  localparam logic [2:0] OFF_VBLO = 3'd4;
  localparam logic [2:0] OFF_VBHI = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } irq_state_t;

  function automatic logic [1:0] prio_id(input logic [NUM_IRQ-1:0] c);
    logic [1:0] r;
    r = '0;
    // Walk downward so the lowest set index is the last assignment.
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (c[i]) r = 2'(i);
    return r;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: 2-flop synchronizer for one asynchronous interrupt line,
// plus rising-edge detect on the synchronized level.
//   clk, reset (async, active low)
//   d      - raw asynchronous input
//   level  - synchronized level
//   rise   - one-cycle pulse in the cycle level first reads 1
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: four-line interrupt controller.
// Synchronizes irq_in, latches pending bits, picks the lowest enabled
// pending line, presents irq_req + irq_vector to the CPU and sequences
// the irq_ack / irq_clr handshake.
// Ports:
//   clk, reset (async, active low)
//   irq_in[3:0]     peripheral lines (async)
//   irq_clr[3:0]    one-cycle clear pulse to the serviced peripheral
//   bus_addr/wdata/we/re, bus_rdata (registered) - byte register file
//   irq_req, irq_vector, irq_ack - CPU handshake
// Registers at BASE_ADDR+: 0 MASK, 1 PEND (W1C), 2 EDGE, 3 STAT,
// 4/5 VBASE_LO/HI when IRQ_CTRL_VBASE_EN is defined (otherwise read 0).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR        = 16'h1010,
  parameter logic [15:0] VEC_BASE_DEFAULT = 16'h0008,
  parameter int unsigned VEC_STRIDE       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] irq_clr,
  input  logic [15:0]        bus_addr,
  input  logic [7:0]         bus_wdata,
  input  logic               bus_we,
  input  logic               bus_re,
  output logic [7:0]         bus_rdata,
  output logic               irq_req,
  output logic [15:0]        irq_vector,
  input  logic               irq_ack
);

  localparam int unsigned STRIDE_SH = $clog2(VEC_STRIDE);

  logic [NUM_IRQ-1:0] lvl, rise, set, cand, w1c, clr_ack, pend_d, mask_d;
  logic [NUM_IRQ-1:0] mask_q, pend_q, edge_q;
  irq_state_t         state_q, state_d;
  logic [1:0]         id_q, id_d;
  logic [15:0]        vec_q, vec_d, vbase, off;
  logic               hit, wr;
  logic [7:0]         rd_val, rdata_q;
  logic               unused_wdata;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (irq_in[g]),
      .level (lvl[g]),
      .rise  (rise[g])
    );
  end

  // Wrapping subtract: anything below BASE_ADDR lands far above 5.
  assign off = bus_addr - BASE_ADDR;
  assign hit = off < 16'd6;
  assign wr  = bus_we & hit;

  assign set     = (edge_q & rise) | (~edge_q & lvl);
  assign clr_ack = (state_q == ACK) ? NUM_IRQ'(1 << id_q) : '0;
  assign w1c     = (wr && off[2:0] == OFF_PEND) ? bus_wdata[NUM_IRQ-1:0] : '0;
  // Hardware set takes precedence over any clear in the same cycle.
  assign pend_d  = (pend_q & ~(w1c | clr_ack)) | set;
  assign mask_d  = (wr && off[2:0] == OFF_MASK) ? bus_wdata[NUM_IRQ-1:0] : mask_q;
  assign cand    = pend_q & mask_q;

  assign unused_wdata = ^bus_wdata[7:NUM_IRQ];

`ifdef IRQ_CTRL_VBASE_EN
  logic [15:0] vbase_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vbase_q <= VEC_BASE_DEFAULT;
    else if (wr && off[2:0] == OFF_VBLO) vbase_q[7:0]  <= bus_wdata;
    else if (wr && off[2:0] == OFF_VBHI) vbase_q[15:8] <= bus_wdata;
  end
  assign vbase = vbase_q;
`else
  assign vbase = VEC_BASE_DEFAULT;
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: if (|cand) begin
        id_d    = prio_id(cand);
        vec_d   = vbase + ({14'd0, id_d} << STRIDE_SH);
        state_d = REQ;
      end
      // Ack beats a same-cycle software clear; otherwise a cleared
      // PEND/MASK bit (after hardware set wins) withdraws the request.
      REQ: if (irq_ack) state_d = ACK;
           else if (!(pend_d[id_q] & mask_d[id_q])) state_d = IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (off[2:0])
      OFF_MASK: rd_val = 8'(mask_q);
      OFF_PEND: rd_val = 8'(pend_q);
      OFF_EDGE: rd_val = 8'(edge_q);
      OFF_STAT: rd_val = {irq_req, 5'd0, id_q};
`ifdef IRQ_CTRL_VBASE_EN
      OFF_VBLO: rd_val = vbase_q[7:0];
      OFF_VBHI: rd_val = vbase_q[15:8];
`endif
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      vec_q   <= VEC_BASE_DEFAULT;
      mask_q  <= '0;
      pend_q  <= '0;
      edge_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      if (wr && off[2:0] == OFF_EDGE) edge_q <= bus_wdata[NUM_IRQ-1:0];
      if (bus_re) rdata_q <= hit ? rd_val : 8'h00;
    end
  end

  assign irq_req    = (state_q == REQ);
  assign irq_clr    = clr_ack;
  assign irq_vector = vec_q;
  assign bus_rdata  = rdata_q;

endmodule
